// File: rtl/rtl_sram_lsu.sv
// Load/store front end for a single-port synchronous SRAM (1-cycle registered read).
// Partial-strobe stores are done as an internal read-modify-write.

`ifndef MEM_ADDR_W
`define MEM_ADDR_W 10
`endif
`ifndef MEM_DATA_W
`define MEM_DATA_W 32
`endif

module rtl_sram_lsu_byte_merge (
  input  logic       use_new,
  input  logic [7:0] new_byte,
  input  logic [7:0] old_byte,
  output logic [7:0] merged
);
  assign merged = use_new ? new_byte : old_byte;
endmodule

module rtl_sram_lsu #(
  parameter int ADDR_W = `MEM_ADDR_W,
  parameter int DATA_W = `MEM_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy,
  output logic                sram_ce,
  output logic                sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RD_DATA, RMW_MERGE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } cap_t;

  state_t            state, state_nxt;
  cap_t              cap;
  logic              cap_en;
  logic              fire;
  logic              strb_full;
  logic              strb_none;
  logic [DATA_W-1:0] merged;

  // Held low in reset so no request can be taken while the flops are cleared.
  assign req_ready = rst_n && (state == IDLE) && (!rsp_valid || rsp_ready);
  assign fire      = req_valid && req_ready;
  assign strb_full = &req_wstrb;
  assign strb_none = ~|req_wstrb;
  assign busy      = (state != IDLE);

  for (genvar b = 0; b < STRB_W; b++) begin : g_byte
    rtl_sram_lsu_byte_merge u_merge (
      .use_new  (cap.wstrb[b]),
      .new_byte (cap.wdata[8*b +: 8]),
      .old_byte (sram_rdata[8*b +: 8]),
      .merged   (merged[8*b +: 8])
    );
  end

  always_comb begin
    state_nxt  = state;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    cap_en     = 1'b0;
    case (state)
      IDLE: begin
        if (fire) begin
          if (!req_we) begin
            sram_ce   = 1'b1;
            sram_addr = req_addr;
            state_nxt = RD_DATA;
          end else if (strb_full) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = req_addr;
            sram_wdata = req_wdata;
          end else if (!strb_none) begin
            sram_ce   = 1'b1;
            sram_addr = req_addr;
            cap_en    = 1'b1;
            state_nxt = RMW_MERGE;
          end
        end
      end
      RD_DATA:   state_nxt = IDLE;
      RMW_MERGE: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = cap.addr;
        sram_wdata = merged;
        state_nxt  = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
    // An interrupted merge must never reach the array.
    if (!rst_n) begin
      sram_ce    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (cap_en) cap <= '{addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
      if (state == RD_DATA) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= sram_rdata;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rtl_sram_lsu.sv
// Bench for rtl_sram_lsu: SRAM model, word-level reference model, per-cycle compare,
// directed scenarios plus randomized traffic.

module tb_rtl_sram_lsu;
  localparam int AW = 6, DW = 32, SW = 4, DEPTH = 64;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_wstrb = '0;
  logic          req_ready, rsp_valid, busy, sram_ce, sram_we;
  logic [DW-1:0] rsp_rdata, sram_wdata, sram_rdata;
  logic [AW-1:0] sram_addr;
  int            checks = 0, errors = 0;

  always #5 clk = ~clk;

  rtl_sram_lsu #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < SW; i++) if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous single-port SRAM with registered read.
  logic [DW-1:0] sram_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_word(i);
    sram_rdata <= '0;
    forever begin
      @(posedge clk);
      if (sram_ce) begin
        if (sram_we) sram_mem[sram_addr] <= sram_wdata;
        else         sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model: word memory updated at store acceptance, one op in flight.
  logic [DW-1:0] ref_mem [DEPTH];
  logic          m_wait, m_rmw, m_rsp_valid;
  logic [DW-1:0] m_rsp_data, m_load_data, m_old;
  logic [AW-1:0] m_cap_addr;
  initial begin
    logic acc;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    m_wait = 1'b0; m_rmw = 1'b0; m_rsp_valid = 1'b0;
    m_rsp_data = '0; m_load_data = '0; m_old = '0; m_cap_addr = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        if (m_wait && m_rmw) ref_mem[m_cap_addr] = m_old;
        m_wait = 1'b0; m_rmw = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0;
      end else begin
        acc = req_valid && !m_wait && (!m_rsp_valid || rsp_ready);
        if (m_wait && !m_rmw) begin
          m_rsp_valid = 1'b1;
          m_rsp_data  = m_load_data;
        end else if (m_rsp_valid && rsp_ready) begin
          m_rsp_valid = 1'b0;
        end
        if (m_wait) begin
          m_wait = 1'b0; m_rmw = 1'b0;
        end else if (acc) begin
          if (!req_we) begin
            m_load_data = ref_mem[req_addr];
            m_wait = 1'b1;
          end else if (req_wstrb != '0) begin
            m_old = ref_mem[req_addr];
            ref_mem[req_addr] = merge(m_old, req_wdata, req_wstrb);
            if (req_wstrb != '1) begin
              m_wait = 1'b1; m_rmw = 1'b1; m_cap_addr = req_addr;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    logic exp_ready, acc, exp_ce, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_rdata", rsp_rdata, 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_sram_ce", 32'(sram_ce), 32'(0));
        chk("rst_sram_we", 32'(sram_we), 32'(0));
      end else begin
        exp_ready = !m_wait && (!m_rsp_valid || rsp_ready);
        acc = req_valid && exp_ready;
        exp_ce = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        if (m_wait && m_rmw) begin
          exp_ce = 1'b1; exp_we = 1'b1; exp_addr = m_cap_addr; exp_wdata = ref_mem[m_cap_addr];
        end else if (!m_wait && acc) begin
          if (!req_we) begin
            exp_ce = 1'b1; exp_addr = req_addr;
          end else if (req_wstrb == '1) begin
            exp_ce = 1'b1; exp_we = 1'b1; exp_addr = req_addr; exp_wdata = req_wdata;
          end else if (req_wstrb != '0) begin
            exp_ce = 1'b1; exp_addr = req_addr;
          end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(m_wait));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        chk("rsp_rdata", rsp_rdata, m_rsp_data);
        chk("sram_ce", 32'(sram_ce), 32'(exp_ce));
        chk("sram_we", 32'(sram_we), 32'(exp_we));
        if (exp_ce) chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
        if (exp_we) chk("sram_wdata", sram_wdata, exp_wdata);
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output int waited);
    waited = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=%0d cycles required=<50", waited);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic load_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int w;
    do_req(1'b0, a, '0, '0, w);
    @(posedge clk); #1;
    chk({name, "_valid"}, 32'(rsp_valid), 32'(1));
    chk(name, rsp_rdata, exp);
  endtask

  initial begin
    int w;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'(1));
    @(posedge clk); #1;

    // Full store then load
    do_req(1'b1, 6'h10, 32'hDEADBEEF, 4'hF, w);
    chk("full_store_busy", 32'(busy), 32'(0));
    load_check("store_load", 6'h10, 32'hDEADBEEF);

    // Partial store via RMW
    do_req(1'b1, 6'h20, 32'h11223344, 4'hF, w);
    do_req(1'b1, 6'h20, 32'hAABBCCDD, 4'b0101, w);
    chk("rmw_busy_on", 32'(busy), 32'(1));
    @(posedge clk); #1;
    chk("rmw_busy_off", 32'(busy), 32'(0));
    load_check("partial_store", 6'h20, 32'h11BB33DD);

    // Zero strobe leaves the word alone
    do_req(1'b1, 6'h20, 32'hFFFFFFFF, 4'h0, w);
    load_check("zero_strobe", 6'h20, 32'h11BB33DD);

    // Backpressure
    do_req(1'b1, 6'h30, 32'h5, 4'hF, w);
    do_req(1'b1, 6'h31, 32'h6, 4'hF, w);
    rsp_ready = 1'b0;
    do_req(1'b0, 6'h30, '0, '0, w);
    @(posedge clk); #1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_data", rsp_rdata, 32'h5);
      chk("bp_ready_low", 32'(req_ready), 32'(0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    do_req(1'b0, 6'h31, '0, '0, w);
    chk("bp_same_cycle_accept", 32'(w), 32'(0));
    @(posedge clk); #1;
    chk("bp_new_data", rsp_rdata, 32'h6);

    // Reset during the merge cycle
    do_req(1'b1, 6'h02, 32'h12345678, 4'hF, w);
    do_req(1'b1, 6'h02, 32'hFFFFFFFF, 4'b0011, w);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    load_check("rst_in_merge", 6'h02, 32'h12345678);

    // Randomized traffic with one reset in the middle
    for (int c = 0; c < 600; c++) begin
      if (c == 300) rst_n = 1'b0;
      if (c == 303) rst_n = 1'b1;
      req_valid = ($urandom_range(0, 99) < 70);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 15));
      req_wdata = $urandom;
      case ($urandom_range(0, 3))
        0:       req_wstrb = 4'hF;
        1:       req_wstrb = 4'h0;
        default: req_wstrb = SW'($urandom_range(1, 14));
      endcase
      rsp_ready = ($urandom_range(0, 99) < 70);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtl_sram_lsu.md
# rtl_sram_lsu

Load/store front end for the single-port data SRAM, which is synchronous with a 1-cycle registered read. It accepts pipeline MEM-stage requests over a valid/ready handshake, drives the SRAM control pins, and holds read data in a response register with backpressure. Byte-strobed partial writes are performed as internal read-modify-write (RMW) sequences, because the SRAM has no byte enables.

## Interface
- ADDR_W, `MEM_ADDR_W: word address width, equal to SRAM ADDR_W
- DATA_W, `MEM_DATA_W: data width; must be a multiple of 8
- STRB_W, DATA_W/8: byte-strobe width (derived localparam)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_wstrb  in  STRB_W  byte enables; bit i covers byte [8i+7:8i]; ignored for loads
- rsp_valid  out  1  load data available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  DATA_W  load data
- busy  out  1  state != IDLE
- sram_ce  out  1  SRAM chip enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a ce=1, we=0 access

## Operation
- States: IDLE, RD_DATA, RMW_MERGE.
- req_ready = (state==IDLE) && (!rsp_valid || rsp_ready). Combinational; does not depend on req_we.
- SRAM pins are combinational from the current request (IDLE) or from the captured request (RMW_MERGE). Otherwise sram_ce=0, sram_we=0, and sram_addr/sram_wdata are don't-care (drive 0).
- Load accept (IDLE): sram_ce=1, sram_we=0, sram_addr=req_addr, then go to RD_DATA.
- RD_DATA: sram_rdata is valid. At the end of the cycle, rsp_rdata<=sram_rdata and rsp_valid<=1, then go to IDLE.
- Store accept, wstrb all ones: sram_ce=1, sram_we=1, wdata=req_wdata in the same cycle. Stay in IDLE. No response.
- Store accept, wstrb all zero: no SRAM access. Stay in IDLE. No response.
- Store accept, partial wstrb: issue an SRAM read of req_addr and capture addr/wdata/wstrb. Go to RMW_MERGE.
- RMW_MERGE: sram_ce=1, sram_we=1, sram_addr=captured addr. Each byte of sram_wdata comes from the captured wdata where the strobe bit is 1, else from sram_rdata. Then go to IDLE.
- Stores never produce a response, but they obey the same req_ready rule.
- rsp_valid clears on rsp_valid && rsp_ready unless reloaded in the same cycle; the reload wins.
- rsp_rdata is held stable while rsp_valid && !rsp_ready.
- Ordering: one request is in flight at a time, so a load after any store returns the post-store data.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, busy=0. With state IDLE and rsp_valid=0, req_ready=1 once rst_n is deasserted. All sram_* outputs are 0 during reset.
- Load latency: accept at edge N, SRAM samples at N, rsp_valid=1 after edge N+1. Peak throughput is 1 load per 2 cycles with rsp_ready held high.
- Full/zero-strobe store: 1 cycle, back-to-back allowed.
- Partial store: 2 cycles; req_ready=0 during RMW_MERGE.
- Response full (rsp_valid && !rsp_ready): req_ready=0 and no SRAM access is issued.
- A load accepted in the same cycle rsp_ready drains the old response is legal; the new data lands 2 edges later.
- Reset asserted mid-RD_DATA or mid-RMW_MERGE: return to IDLE immediately. The pending response is discarded. No SRAM write is issued (sram_we=0 while rst_n=0), so the memory word is unchanged.
- Request inputs must be held only during the accept cycle; the RMW path uses captured copies.

## Test plan
- Reset: rst_n low for 3 cycles mid-traffic -> rsp_valid=0, rsp_rdata=0, sram_ce=0; req_ready=1 on the first cycle after release.
- Store then load: store addr 0x010, data 0xDEADBEEF, wstrb 4'hF; then load 0x010 -> rsp_rdata=0xDEADBEEF exactly 2 edges after load accept; store takes 1 cycle.
- Partial store: word 0x11223344 at 0x020; store wdata 0xAABBCCDD, wstrb 4'b0101, then load -> 0x11BB33DD; busy=1 for exactly 1 cycle.
- Zero strobe: store wstrb 0 to 0x020 -> sram_ce never asserted; a later load returns the old word unchanged.
- Backpressure: hold rsp_ready=0 after a load of value 0x5 -> rsp_rdata stays 0x5 and req_ready=0; raise rsp_ready together with a new load of value 0x6 -> accepted that cycle, then rsp_rdata=0x6 two edges later.
- Reset during RMW_MERGE: store 0xFFFFFFFF, wstrb 4'b0011 to word 0x12345678; assert rst_n in the MERGE cycle -> after reset, a load returns 0x12345678.
